// File: rtl/soc_pkg.sv
// Shared constants and the memory request bundle for the RV32 SoC shell.
package soc_pkg;
    localparam int          LINE_W        = 128;
    localparam int          MEM_LINES     = 1024;
    localparam int          ADDR_LINE_LSB = 4;
    localparam int          ADDR_LINE_MSB = 13;
    localparam logic [31:0] RESET_PC      = 32'h0000_0000;
    localparam int          STRB_W        = LINE_W / 8;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [31:0]       addr;
        logic [LINE_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;
endpackage

// File: rtl/line_ram.sv
// Single-port line memory: byte-strobed writes, one-cycle read latency.
module line_ram
    import soc_pkg::*;
#(
    parameter int MEM_LINES = soc_pkg::MEM_LINES
) (
    input  logic              clk,
    input  logic              rst,
    input  mem_req_t          req,
    output logic              rvalid,
    output logic [LINE_W-1:0] rdata
);
    reg [LINE_W-1:0] data [0:MEM_LINES-1];

    logic [ADDR_LINE_MSB-ADDR_LINE_LSB:0] line_idx;
    logic                                 rvalid_q;
    logic                                 unused_addr;

    assign line_idx    = req.addr[ADDR_LINE_MSB:ADDR_LINE_LSB];
    assign unused_addr = ^{req.addr[31:ADDR_LINE_MSB+1], req.addr[ADDR_LINE_LSB-1:0]};

    // Contents are never reset; rdata only moves on a read so it holds between responses.
    always_ff @(posedge clk) begin
        if (!rst && req.valid) begin
            if (req.we) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (req.wstrb[b]) data[line_idx][8*b +: 8] <= req.wdata[8*b +: 8];
                end
            end else begin
                rdata <= data[line_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rvalid_q <= 1'b0;
        else     rvalid_q <= req.valid & ~req.we;
    end

    // A response already in flight when reset arrives is swallowed, not delivered.
    assign rvalid = rvalid_q & ~rst;
endmodule

// File: rtl/rv32_core.sv
// Compact multi-cycle RV32I core with separate fetch and data request ports.
module rv32_core
    import soc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = soc_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              i_valid,
    input  logic              i_ready,
    output logic [31:0]       i_addr,
    input  logic              i_rvalid,
    input  logic [LINE_W-1:0] i_rdata,
    output logic              d_valid,
    input  logic              d_ready,
    output logic              d_we,
    output logic [31:0]       d_addr,
    output logic [LINE_W-1:0] d_wdata,
    output logic [STRB_W-1:0] d_wstrb,
    input  logic              d_rvalid,
    input  logic [LINE_W-1:0] d_rdata
);
    localparam logic [1:0] S_FETCH = 2'd0, S_IWAIT = 2'd1, S_EXEC = 2'd2, S_DWAIT = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc, instr, next_pc, wb_data, ld_word, ld_shift, ld_val, alu;
    logic [31:0] regs [0:31];
    logic [31:0] rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_j, imm_u, mem_addr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        is_load, is_store, is_mem, wb_en, taken;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign f3       = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u    = {instr[31:12], 12'd0};
    assign is_load  = (opcode == 7'h03);
    assign is_store = (opcode == 7'h23);
    assign is_mem   = is_load | is_store;
    assign mem_addr = rs1_val + (is_store ? imm_s : imm_i);

    // Valid/ready: a port raises valid with stable fields and a request is taken in any
    // cycle where valid && ready. Memory ops also prefetch pc+4 so the next fetch queues behind them.
    assign i_valid = (state == S_FETCH) || (state == S_DWAIT) || (state == S_EXEC && is_mem);
    assign i_addr  = (state == S_FETCH) ? pc : pc + 32'd4;
    assign d_valid = (state == S_EXEC) && is_mem;
    assign d_we    = is_store;
    assign d_addr  = mem_addr;

    always_comb begin
        d_wdata = {4{rs2_val}};
        d_wstrb = 16'hF << {mem_addr[3:2], 2'b00};
        case (f3[1:0])
            2'd0: begin d_wdata = {16{rs2_val[7:0]}};  d_wstrb = 16'h1 << mem_addr[3:0]; end
            2'd1: begin d_wdata = {8{rs2_val[15:0]}};  d_wstrb = 16'h3 << {mem_addr[3:1], 1'b0}; end
            default: ;
        endcase
    end

    always_comb begin
        ld_word  = d_rdata[{mem_addr[3:2], 5'd0} +: 32];
        ld_shift = ld_word >> {mem_addr[1:0], 3'd0};
        case (f3)
            3'd0:    ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'd1:    ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'd4:    ld_val = {24'd0, ld_shift[7:0]};
            3'd5:    ld_val = {16'd0, ld_shift[15:0]};
            default: ld_val = ld_word;
        endcase
    end

    always_comb begin
        case (f3)
            3'd0:    alu = rs1_val + imm_i;
            3'd1:    alu = rs1_val << imm_i[4:0];
            3'd2:    alu = {31'd0, $signed(rs1_val) < $signed(imm_i)};
            3'd3:    alu = {31'd0, rs1_val < imm_i};
            3'd4:    alu = rs1_val ^ imm_i;
            3'd5:    alu = instr[30] ? 32'($signed(rs1_val) >>> imm_i[4:0]) : rs1_val >> imm_i[4:0];
            3'd6:    alu = rs1_val | imm_i;
            default: alu = rs1_val & imm_i;
        endcase
        case (f3)
            3'd0:    taken = (rs1_val == rs2_val);
            3'd1:    taken = (rs1_val != rs2_val);
            3'd4:    taken = $signed(rs1_val) < $signed(rs2_val);
            3'd5:    taken = $signed(rs1_val) >= $signed(rs2_val);
            3'd6:    taken = rs1_val < rs2_val;
            3'd7:    taken = rs1_val >= rs2_val;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        wb_en   = 1'b0;
        wb_data = 32'd0;
        next_pc = pc + 32'd4;
        case (opcode)
            7'h37: begin wb_en = 1'b1; wb_data = imm_u; end
            7'h17: begin wb_en = 1'b1; wb_data = pc + imm_u; end
            7'h13: begin wb_en = 1'b1; wb_data = alu; end
            7'h6f: begin wb_en = 1'b1; wb_data = pc + 32'd4; next_pc = pc + imm_j; end
            7'h67: begin wb_en = 1'b1; wb_data = pc + 32'd4; next_pc = (rs1_val + imm_i) & ~32'd1; end
            7'h63: if (taken) next_pc = pc + imm_b;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
        end else begin
            case (state)
                S_FETCH: if (i_ready) state <= S_IWAIT;
                S_IWAIT: if (i_rvalid) begin
                    instr <= i_rdata[{pc[3:2], 5'd0} +: 32];
                    state <= S_EXEC;
                end
                S_EXEC: if (!is_mem) begin
                    pc    <= next_pc;
                    state <= S_FETCH;
                end else if (d_ready) begin
                    if (is_store) begin
                        pc    <= pc + 32'd4;
                        state <= S_FETCH;
                    end else begin
                        state <= S_DWAIT;
                    end
                end
                default: if (i_ready) begin
                    pc    <= pc + 32'd4;
                    state <= S_IWAIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rd != 5'd0) begin
            if (state == S_EXEC && wb_en)         regs[rd] <= wb_data;
            else if (state == S_DWAIT && d_rvalid) regs[rd] <= ld_val;
        end
    end
endmodule

// File: rtl/riscv_soc_wrapper.sv
// SoC shell: RV32 core, a data-priority single-port arbiter and the unified line memory.
module riscv_soc_wrapper
    import soc_pkg::*;
#(
    parameter int          MEM_LINES = soc_pkg::MEM_LINES,
    parameter int          LINE_W    = soc_pkg::LINE_W,
    parameter logic [31:0] RESET_PC  = soc_pkg::RESET_PC
) (
    input logic CLK,
    input logic RST
);
    logic                i_valid, i_ready, i_rvalid;
    logic [31:0]         i_addr;
    logic [LINE_W-1:0]   i_rdata;
    logic                d_valid, d_ready, d_we, d_rvalid;
    logic [31:0]         d_addr;
    logic [LINE_W-1:0]   d_wdata, d_rdata;
    logic [LINE_W/8-1:0] d_wstrb;
    mem_req_t            ram_req;
    logic                ram_rvalid;
    logic [LINE_W-1:0]   ram_rdata;
    logic                resp_to_d;

    rv32_core #(.RESET_PC(RESET_PC)) cpu (
        .clk      (CLK),
        .rst      (RST),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_addr   (i_addr),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wstrb  (d_wstrb),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata)
    );

    // Data wins ties; the fetch waits with its request held. Nothing is granted under reset.
    always_comb begin
        d_ready = d_valid & ~RST;
        i_ready = i_valid & ~d_valid & ~RST;
        ram_req = '0;
        if (d_ready) begin
            ram_req.valid = 1'b1;
            ram_req.we    = d_we;
            ram_req.addr  = d_addr;
            ram_req.wdata = d_wdata;
            ram_req.wstrb = d_wstrb;
        end else if (i_ready) begin
            ram_req.valid = 1'b1;
            ram_req.addr  = i_addr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)                resp_to_d <= 1'b0;
        else if (ram_req.valid) resp_to_d <= d_ready;
    end

    assign i_rvalid = ram_rvalid & ~resp_to_d;
    assign d_rvalid = ram_rvalid & resp_to_d;
    assign i_rdata  = ram_rdata;
    assign d_rdata  = ram_rdata;

    line_ram #(.MEM_LINES(MEM_LINES)) ram (
        .clk    (CLK),
        .rst    (RST),
        .req    (ram_req),
        .rvalid (ram_rvalid),
        .rdata  (ram_rdata)
    );
endmodule

// File: tb/tb_riscv_soc_wrapper.sv
// Directed bench: runs two small programs from preloaded memory and checks bus timing and results.
module tb_riscv_soc_wrapper;
    logic CLK, RST;
    int   total, bad;
    logic watch, saw_neg1, found;
    int   n, pulses;
    logic [127:0] line;

    riscv_soc_wrapper dut (
        .CLK (CLK),
        .RST (RST)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (watch && dut.cpu.regs[31] === 32'hffff_ffff) saw_neg1 = 1'b1;
    end

    initial begin
        total = 0; bad = 0; watch = 1'b0; saw_neg1 = 1'b0; found = 1'b0; n = 0; pulses = 0;
        RST = 1'b1;
        dut.ram.data[0]   = 128'hfff14193_0800a103_800015b7_800000b7;
        dut.ram.data[1]   = 128'h02c18263_02c10463_0805a603_0830a023;
        dut.ram.data[2]   = 128'h00321a63_0800a203_08d5a023_fff64693;
        dut.ram.data[3]   = 128'h0000006f_00100f93_00d71663_0805a703;
        dut.ram.data[4]   = 128'h0000006f_fff00f93;
        dut.ram.data[8]   = 128'h01010101;
        dut.ram.data[264] = 128'habababab;
        repeat (5) @(negedge CLK);

        // reset state
        check("rst_i_addr", dut.i_addr, 32'h0);
        check("rst_grant", {dut.i_ready, dut.d_ready}, 2'b00);
        check("rst_rvalid", dut.ram.rvalid, 1'b0);
        RST = 1'b0;
        watch = 1'b1;
        #1 check("first_fetch", {dut.i_valid, dut.i_ready, dut.i_addr}, {2'b11, 32'h0});

        // first lw at 0x08 raises d_valid together with the pc+4 prefetch
        for (int k = 0; k < 50; k++) begin
            @(negedge CLK);
            n++;
            if (dut.i_valid && dut.d_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("arb_seen", found, 1'b1);
        check("arb_grant", {dut.d_ready, dut.i_ready, dut.i_addr}, {2'b10, 32'h0000_000c});
        @(negedge CLK);
        check("arb_fetch_next", {dut.i_ready, dut.d_rvalid, dut.i_rvalid}, 3'b110);
        check("arb_d_rdata", dut.d_rdata, 128'h01010101);
        @(negedge CLK);
        check("arb_i_rvalid", {dut.i_rvalid, dut.d_rvalid}, 2'b10);
        check("arb_i_rdata", dut.i_rdata, 128'hfff14193_0800a103_800015b7_800000b7);
        repeat (200 - n - 2) @(negedge CLK);

        check("lock_x31", dut.cpu.regs[31], 32'h1);
        line = dut.ram.data[8];
        check("lock_d8", line[31:0], 32'hfefefefe);
        line = dut.ram.data[264];
        check("lock_d264", line[31:0], 32'h54545454);
        check("lock_never_neg1", saw_neg1, 1'b0);
        watch = 1'b0;

        // reset persistence, loading the alias/strobe program while held in reset
        RST = 1'b1;
        dut.ram.data[5] = 128'h1234;
        dut.ram.data[0] = 128'h67838393_123453b7_80000337_08000293;
        dut.ram.data[1] = 128'h089302a3_0ab00493_08032403_0072a023;
        dut.ram.data[2] = 128'h0000006f;
        dut.ram.data[8] = 128'h01234567_89abcdef_fedcba98_76543210;
        repeat (3) @(negedge CLK);
        line = dut.ram.data[5];
        check("persist_d5", line, 128'h1234);
        RST = 1'b0;
        #1 check("persist_fetch", {dut.i_valid, dut.i_ready, dut.i_addr}, {2'b11, 32'h0});
        repeat (80) @(negedge CLK);
        check("alias_x8", dut.cpu.regs[8], 32'h1234_5678);
        line = dut.ram.data[8];
        check("strobe_d8", line, 128'h01234567_89abcdef_fedcab98_12345678);

        // reset arriving while a load response is in flight
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (dut.d_valid && dut.d_ready && !dut.d_we) begin
                found = 1'b1;
                break;
            end
        end
        check("midread_seen", found, 1'b1);
        @(posedge CLK);
        #1 RST = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            if (dut.ram.rvalid || dut.d_rvalid || dut.i_rvalid) pulses++;
        end
        check("midread_no_rvalid", pulses, 0);
        RST = 1'b0;
        #1 check("midread_resume", {dut.i_valid, dut.i_ready, dut.i_addr}, {2'b11, 32'h0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/riscv_soc_wrapper.md
Name: riscv_soc_wrapper

Overview:
- Top-level shell for the RV32 CPU.
- Instantiates the existing core as instance `cpu` and a line-organised unified memory as instance `ram`. Between them sits a single-port arbiter that merges the core's instruction-fetch and data request ports.
- The block's only ports are clock and reset; benches preload and inspect memory hierarchically through `ram.data[]`.

Parameters:
- MEM_LINES, 1024, number of 128-bit lines in `ram` (16 KiB).
- LINE_W, 128, memory line width in bits.
- RESET_PC, 32'h0000_0000, core fetch address after reset.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  reset; synchronous, active-high.

Behaviour:
- Reset:
  - RST is synchronous and active-high.
  - It resets the core (PC to RESET_PC, pipeline flushed), the arbiter (idle, no grant) and the ram response-valid flag.
  - Memory contents are never cleared by reset, and the memory has no initialisation. Writes to `ram.data[i]` during or after reset must persist until the core overwrites them.
- Memory array:
  - `ram` declares `reg [127:0] data [0:MEM_LINES-1]`.
  - The array name `data` and the instance name `ram` are fixed.
- Address decode:
  - line index = addr[13:4]; word within line = addr[3:2]; byte = addr[1:0].
  - Upper address bits are ignored, so memory aliases across the whole 4 GiB space. For example, 0x8000_0080 selects data[8], 0x8000_1080 selects data[264], and PC 0x0 selects data[0].
- Lane mapping: word k of a line occupies bits [32k+31:32k], little-endian, with byte b of the word at bits [8b+7:8b].
- Core ports:
  - Instruction port: i_valid/i_ready, i_addr[31:0], i_rdata[127:0].
  - Data port: d_valid/d_ready, d_we, d_addr[31:0], d_wdata[127:0], d_wstrb[15:0], d_rdata[127:0].
  - The core performs lane extraction and alignment itself.
- Arbiter:
  - One ram access is accepted per cycle.
  - On simultaneous requests the data port has priority.
  - The losing port holds its valid and request fields stable until it is granted.
- Handshake: a request is accepted when valid && ready.
- Read timing:
  - Read data returns on the rdata of the granted port exactly 1 cycle after acceptance, with r_valid high for that one cycle.
  - rdata holds its value until the next read response.
- Write timing:
  - A write accepted in cycle N commits at the rising edge ending cycle N, updating only bytes whose d_wstrb bit is set.
  - A read of the same line accepted in cycle N+1 returns the new data.
  - Writes produce no response beat.
- Reset during an outstanding read: the response is dropped and no r_valid is issued. A write accepted in the same cycle that RST is high is ignored.
- No exceptions on misalignment: d_wstrb is taken as given.

Decomposition:
- Shared package `soc_pkg`:
  - Constants: LINE_W, MEM_LINES, ADDR_LINE_LSB=4, ADDR_LINE_MSB=13, RESET_PC.
  - Typedef: mem_req_t, holding valid, we, addr, wdata, wstrb.
- Sub-module: `line_ram` (instance name `ram`). Single-port, byte-strobed, 1-cycle read latency.
- The arbiter is kept inline in the wrapper.
- The core is an existing module, not part of this block.

Test Plan:
- Memory-lock test:
  - Stimulus: preload data[0]=128'hfff14193_0800a103_800015b7_800000b7, data[1]=128'h02c18263_02c10463_0805a603_0830a023, data[2]=128'h00321a63_0800a203_08d5a023_fff64693, data[3]=128'h0000006f_00100f93_00d71663_0805a703, data[4]=128'h0000006f_fff00f93, data[8]=32'h01010101, data[264]=32'hABABABAB; pulse RST high for 5 cycles; then run 200 cycles.
  - Required: x31=1 (pass loop at PC 0x3C), data[8][31:0]=FEFEFEFE, data[264][31:0]=54545454; x31 never equals 0xFFFFFFFF.
- Aliasing: a store to 0x0000_0080 and a load from 0x8000_0080 both hit data[8], and the load returns the stored value.
- Byte strobe: sb of 0xAB to 0x8000_0085 changes only data[8][47:40]; all other bytes of the line are unchanged.
- Arbitration: force simultaneous i_valid and d_valid.
  - Required: the data request is granted first and the fetch is granted the following cycle; rdata latency is exactly 1 cycle after each grant.
- Reset persistence: preload data[5]=128'h1234, then assert RST for 3 cycles. Required: data[5] still reads 128'h1234 and the first fetch after release is from address 0x0.
- Reset mid-read: assert RST in the cycle after a load is accepted. Required: no r_valid pulse, and the core resumes fetching at RESET_PC.
